// File: rtl/inflate_hdr_seq.sv
// inflate_hdr_seq: per-block sequencer for the inflate core.
// It reads the DEFLATE block header, writes the code-length-code lengths in permuted order,
// then runs the CL table build, length extraction, lit/dist tree build and symbol decode.
// Optional feature macro: INFLATE_FIXED_EN (fixed-Huffman blocks, BTYPE 01).
module inflate_hdr_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       bs_req,
  output logic [2:0] bs_len,
  input  logic [4:0] bs_data,
  input  logic       bs_ack,
  output logic       clen_we,
  output logic [4:0] clen_waddr,
  output logic [2:0] clen_wdata,
  output logic       blk_flush,
  output logic       cl_start,
  input  logic       cl_done,
  output logic       lens_start,
  output logic [8:0] lens_count,
  input  logic       lens_finish,
  output logic       tree_start,
  input  logic       tree_done,
  output logic       sym_start,
  input  logic       sym_eob,
  output logic       fixed_mode,
  output logic       busy,
  output logic       done,
  output logic       hdr_err
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StBhdr    = 4'd1;
  localparam logic [3:0] StHlit    = 4'd2;
  localparam logic [3:0] StHdist   = 4'd3;
  localparam logic [3:0] StHclen   = 4'd4;
  localparam logic [3:0] StClen    = 4'd5;
  localparam logic [3:0] StZfill   = 4'd6;
  localparam logic [3:0] StClbuild = 4'd7;
  localparam logic [3:0] StLens    = 4'd8;
  localparam logic [3:0] StTbuild  = 4'd9;
  localparam logic [3:0] StData    = 4'd10;
  localparam logic [3:0] StErr     = 4'd11;

  // Storage order of the code-length-code lengths.
  function automatic logic [4:0] perm(input logic [4:0] k);
    case (k)
      5'd0:  perm = 5'd16;
      5'd1:  perm = 5'd17;
      5'd2:  perm = 5'd18;
      5'd3:  perm = 5'd0;
      5'd4:  perm = 5'd8;
      5'd5:  perm = 5'd7;
      5'd6:  perm = 5'd9;
      5'd7:  perm = 5'd6;
      5'd8:  perm = 5'd10;
      5'd9:  perm = 5'd5;
      5'd10: perm = 5'd11;
      5'd11: perm = 5'd4;
      5'd12: perm = 5'd12;
      5'd13: perm = 5'd3;
      5'd14: perm = 5'd13;
      5'd15: perm = 5'd2;
      5'd16: perm = 5'd14;
      5'd17: perm = 5'd1;
      5'd18: perm = 5'd15;
      default: perm = 5'd0;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic       first_q, armed_q, bs_req_q, bs_req_d;
  logic       bfinal_q, bfinal_d;
  logic [4:0] hlit_q, hlit_d, hdist_q, hdist_d, k_q, k_d;
  logic [3:0] hclen_q, hclen_d;
  logic       clen_we_q, clen_we_d;
  logic [4:0] clen_waddr_q, clen_waddr_d;
  logic [2:0] clen_wdata_q, clen_wdata_d;
  logic [8:0] lens_count_q, lens_count_d;
  logic       blk_flush_q, cl_start_q, lens_start_q, tree_start_q, sym_start_q, done_q, done_d;
  logic       hdr_err_q;
  logic       ack_ok, req_state, any_start;
`ifdef INFLATE_FIXED_EN
  logic       fixed_q, fixed_d;
`endif

  assign ack_ok    = bs_req_q & bs_ack;
  assign req_state = state_q inside {StBhdr, StHlit, StHdist, StHclen, StClen};
  assign any_start = cl_start_q | lens_start_q | tree_start_q | sym_start_q;

  // Next-state, field latching and CL buffer write generation.
  always_comb begin
    state_d      = state_q;
    bfinal_d     = bfinal_q;
    hlit_d       = hlit_q;
    hdist_d      = hdist_q;
    hclen_d      = hclen_q;
    k_d          = k_q;
    clen_we_d    = 1'b0;
    clen_waddr_d = clen_waddr_q;
    clen_wdata_d = clen_wdata_q;
    lens_count_d = lens_count_q;
    done_d       = 1'b0;
`ifdef INFLATE_FIXED_EN
    fixed_d      = fixed_q;
`endif
    case (state_q)
      StIdle, StErr: if (start) state_d = StBhdr;
      StBhdr: if (ack_ok) begin
        bfinal_d = bs_data[0];
        case (bs_data[2:1])
          2'b10: state_d = StHlit;
`ifdef INFLATE_FIXED_EN
          2'b01: begin
            fixed_d = 1'b1;
            state_d = StTbuild;
          end
`endif
          default: state_d = StErr;
        endcase
      end
      StHlit: if (ack_ok) begin
        hlit_d  = bs_data;
        state_d = StHdist;
      end
      StHdist: if (ack_ok) begin
        hdist_d      = bs_data;
        lens_count_d = {4'b0, hlit_q} + 9'd257 + {4'b0, bs_data} + 9'd1;
        // More than 316 lengths cannot be valid; reject before any CL work.
        state_d      = (hlit_q > 5'd29 || bs_data > 5'd29) ? StErr : StHclen;
      end
      StHclen: if (ack_ok) begin
        hclen_d = bs_data[3:0];
        k_d     = 5'd0;
        state_d = StClen;
      end
      StClen: if (ack_ok) begin
        clen_we_d    = 1'b1;
        clen_waddr_d = perm(k_q);
        clen_wdata_d = bs_data[2:0];
        k_d          = k_q + 5'd1;
        if (k_q == {1'b0, hclen_q} + 5'd3) state_d = (hclen_q == 4'd15) ? StClbuild : StZfill;
      end
      StZfill: begin
        clen_we_d    = 1'b1;
        clen_waddr_d = perm(k_q);
        clen_wdata_d = 3'd0;
        k_d          = k_q + 5'd1;
        if (k_q == 5'd18) state_d = StClbuild;
      end
      StClbuild: if (armed_q && cl_done) state_d = StLens;
      StLens:    if (armed_q && lens_finish) state_d = StTbuild;
      StTbuild:  if (armed_q && tree_done) state_d = StData;
      StData: if (armed_q && sym_eob) begin
        done_d  = bfinal_q;
        state_d = bfinal_q ? StIdle : StBhdr;
      end
      default: state_d = StIdle;
    endcase
`ifdef INFLATE_FIXED_EN
    if (state_d == StBhdr && state_q != StBhdr) fixed_d = 1'b0;
`endif
    // Request rises one cycle after entry and drops for a cycle after every ack.
    bs_req_d = req_state && (state_d == state_q) && !ack_ok;
  end

  // State, header fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      first_q      <= 1'b0;
      armed_q      <= 1'b0;
      bs_req_q     <= 1'b0;
      bfinal_q     <= 1'b0;
      hlit_q       <= 5'd0;
      hdist_q      <= 5'd0;
      hclen_q      <= 4'd0;
      k_q          <= 5'd0;
      clen_we_q    <= 1'b0;
      clen_waddr_q <= 5'd0;
      clen_wdata_q <= 3'd0;
      lens_count_q <= 9'd0;
      blk_flush_q  <= 1'b0;
      cl_start_q   <= 1'b0;
      lens_start_q <= 1'b0;
      tree_start_q <= 1'b0;
      sym_start_q  <= 1'b0;
      done_q       <= 1'b0;
      hdr_err_q    <= 1'b0;
`ifdef INFLATE_FIXED_EN
      fixed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      first_q      <= (state_d != state_q);
      // A wait state only listens for its done input after its start pulse has gone out.
      armed_q      <= (state_d == state_q) && (armed_q || any_start);
      bs_req_q     <= bs_req_d;
      bfinal_q     <= bfinal_d;
      hlit_q       <= hlit_d;
      hdist_q      <= hdist_d;
      hclen_q      <= hclen_d;
      k_q          <= k_d;
      clen_we_q    <= clen_we_d;
      clen_waddr_q <= clen_waddr_d;
      clen_wdata_q <= clen_wdata_d;
      lens_count_q <= lens_count_d;
      blk_flush_q  <= first_q && (state_q == StBhdr);
      cl_start_q   <= first_q && (state_q == StClbuild);
      lens_start_q <= first_q && (state_q == StLens);
      tree_start_q <= first_q && (state_q == StTbuild);
      sym_start_q  <= first_q && (state_q == StData);
      done_q       <= done_d;
      hdr_err_q    <= (state_d == StErr);
`ifdef INFLATE_FIXED_EN
      fixed_q      <= fixed_d;
`endif
    end
  end

  // Request width follows the field being read.
  always_comb begin
    bs_len = 3'd0;
    case (state_q)
      StBhdr, StClen:  bs_len = 3'd3;
      StHlit, StHdist: bs_len = 3'd5;
      StHclen:         bs_len = 3'd4;
      default:         bs_len = 3'd0;
    endcase
  end

  assign bs_req     = bs_req_q;
  assign clen_we    = clen_we_q;
  assign clen_waddr = clen_waddr_q;
  assign clen_wdata = clen_wdata_q;
  assign blk_flush  = blk_flush_q;
  assign cl_start   = cl_start_q;
  assign lens_start = lens_start_q;
  assign lens_count = lens_count_q;
  assign tree_start = tree_start_q;
  assign sym_start  = sym_start_q;
  assign done       = done_q;
  assign hdr_err    = hdr_err_q;
  assign busy       = (state_q != StIdle) && (state_q != StErr);
`ifdef INFLATE_FIXED_EN
  assign fixed_mode = fixed_q;
`else
  assign fixed_mode = 1'b0;
`endif

endmodule

// File: tb/tb_inflate_hdr_seq.sv
// Directed bench for inflate_hdr_seq: dynamic blocks, ZFILL timing, multi-block,
// header errors, optional fixed blocks (INFLATE_FIXED_EN) and reset in LENS.
module tb_inflate_hdr_seq;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, bs_ack = 1'b0;
  logic       cl_done = 1'b0, lens_finish = 1'b0, tree_done = 1'b0, sym_eob = 1'b0;
  logic [4:0] bs_data = 5'd0;
  logic       bs_req, clen_we, blk_flush, cl_start, lens_start, tree_start, sym_start;
  logic       fixed_mode, busy, done, hdr_err;
  logic [2:0] bs_len, clen_wdata;
  logic [4:0] clen_waddr;
  logic [8:0] lens_count;

  inflate_hdr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bs_req(bs_req), .bs_len(bs_len),
    .bs_data(bs_data), .bs_ack(bs_ack), .clen_we(clen_we), .clen_waddr(clen_waddr),
    .clen_wdata(clen_wdata), .blk_flush(blk_flush), .cl_start(cl_start), .cl_done(cl_done),
    .lens_start(lens_start), .lens_count(lens_count), .lens_finish(lens_finish),
    .tree_start(tree_start), .tree_done(tree_done), .sym_start(sym_start), .sym_eob(sym_eob),
    .fixed_mode(fixed_mode), .busy(busy), .done(done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, cl_cyc = 0;
  int n_flush = 0, n_cl = 0, n_lens = 0, n_tree = 0, n_sym = 0, n_done = 0, n_req = 0;
  int ev[$];
  int wr_addr[$], wr_data[$], wr_cyc[$];
  int perm_tab[19] = '{16, 17, 18, 0, 8, 7, 9, 6, 10, 5, 11, 4, 12, 3, 13, 2, 14, 1, 15};

  // Record pre-edge output values once per cycle.
  always @(posedge clk) begin
    cyc++;
    if (blk_flush)  begin n_flush++; ev.push_back(6); end
    if (cl_start)   begin n_cl++;    ev.push_back(1); cl_cyc = cyc; end
    if (lens_start) begin n_lens++;  ev.push_back(2); end
    if (tree_start) begin n_tree++;  ev.push_back(3); end
    if (sym_start)  begin n_sym++;   ev.push_back(4); end
    if (done)       begin n_done++;  ev.push_back(5); end
    if (bs_req) n_req++;
    if (clen_we) begin
      wr_addr.push_back(int'(clen_waddr));
      wr_data.push_back(int'(clen_wdata));
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for a start pulse: 0 cl, 1 lens, 2 tree, 3 sym.
  task automatic wait_for(input int which, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = cl_start;
        1: seen = lens_start;
        2: seen = tree_start;
        default: seen = sym_start;
      endcase
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  // One-cycle done input: 0 cl_done, 1 lens_finish, 2 tree_done, 3 sym_eob.
  task automatic pulse_in(input int which);
    case (which)
      0: cl_done = 1'b1;
      1: lens_finish = 1'b1;
      2: tree_done = 1'b1;
      default: sym_eob = 1'b1;
    endcase
    @(negedge clk);
    cl_done = 1'b0; lens_finish = 1'b0; tree_done = 1'b0; sym_eob = 1'b0;
  endtask

  task automatic respond(input int which, input string tag);
    wait_for(which, tag);
    @(negedge clk);
    pulse_in(which);
  endtask

  // Serve one bit-reader request with value v, checking the requested width.
  task automatic serve(input int v, input int len, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bs_req;
    end
    check({tag, "_req"}, seen, 1);
    check({tag, "_len"}, bs_len, len);
    bs_data = 5'(v);
    bs_ack  = 1'b1;
    @(negedge clk);
    bs_ack  = 1'b0;
    bs_data = 5'd0;
  endtask

  // Dynamic header through CLBUILD; CL length k is (base - k) & 7.
  task automatic run_block_dyn(input int bfinal, input int hlit, input int hdist, input int hclen,
                               input int base, input bit early);
    int w0 = wr_addr.size();
    int l0 = n_lens;
    serve(4 + bfinal, 3, "bhdr");
    serve(hlit, 5, "hlit");
    serve(hdist, 5, "hdist");
    serve(hclen, 4, "hclen");
    for (int k = 0; k <= hclen + 3; k++) serve((base - k) & 7, 3, "clen");
    wait_for(0, "cl_start");
    if (early) begin
      cl_done = 1'b1;  // same cycle as cl_start: must be ignored
      @(negedge clk);
      cl_done = 1'b0;
      repeat (2) @(negedge clk);
      check("early_cl_done_ignored", n_lens - l0, 0);
    end else begin
      @(negedge clk);
    end
    check("cl_write_count", wr_addr.size() - w0, 19);
    if (wr_addr.size() - w0 == 19) begin
      for (int k = 0; k < 19; k++) begin
        check($sformatf("cl_addr_%0d", k), wr_addr[w0 + k], perm_tab[k]);
        check($sformatf("cl_data_%0d", k), wr_data[w0 + k], (k <= hclen + 3) ? ((base - k) & 7) : 0);
      end
      for (int k = hclen + 3; k < 18; k++)
        check($sformatf("zfill_gap_%0d", k), wr_cyc[w0 + k + 1] - wr_cyc[w0 + k], 1);
      check("cl_start_after_last_write", cl_cyc - wr_cyc[w0 + 18], 1);
    end
    check("lens_count", lens_count, hlit + hdist + 258);
    check("fixed_mode_dyn", fixed_mode, 0);
    pulse_in(0);
  endtask

  task automatic finish_rest(input int bfinal);
    respond(1, "lens_start");
    respond(2, "tree_start");
    respond(3, "sym_start");
    check("done_after_eob", done, bfinal);
  endtask

  initial begin
    int e0, f0, d0, r0, w0, l0, p0, packed_ev;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_bs_req", bs_req, 0);
    check("rst_hdr_err", hdr_err, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_clen_we", clen_we, 0);
    check("idle_lens_count", lens_count, 0);
    check("idle_bs_len", bs_len, 0);
    check("idle_fixed", fixed_mode, 0);
    check("idle_blk_flush", blk_flush, 0);

    // Single final block, maximum HLIT/HDIST/HCLEN.
    e0 = ev.size();
    do_start();
    check("busy_after_start", busy, 1);
    run_block_dyn(1, 29, 29, 15, 0, 1'b1);
    finish_rest(1);
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("event_count", ev.size() - e0, 6);
    packed_ev = 0;
    for (int i = e0; i < ev.size(); i++) packed_ev = packed_ev * 10 + ev[i];
    check("event_order", packed_ev, 612345);

    // Two blocks: HCLEN=0 with ZFILL, then a final block.
    f0 = n_flush;
    d0 = n_done;
    do_start();
    run_block_dyn(0, 0, 0, 0, 3, 1'b0);
    finish_rest(0);
    run_block_dyn(1, 1, 2, 1, 5, 1'b0);
    finish_rest(1);
    @(negedge clk);
    check("two_block_flush", n_flush - f0, 2);
    check("two_block_done", n_done - d0, 1);

    // BTYPE=11 -> ERR, then recover via start.
    do_start();
    serve(6, 3, "bhdr11");
    check("btype11_hdr_err", hdr_err, 1);
    check("btype11_busy", busy, 0);
    r0 = n_req;
    repeat (8) @(negedge clk);
    check("err_no_req", n_req - r0, 0);
    do_start();
    check("err_cleared", hdr_err, 0);
    w0 = wr_addr.size();
    serve(3, 3, "bhdr01");
`ifdef INFLATE_FIXED_EN
    wait_for(2, "fixed_tree_start");
    check("fixed_mode_set", fixed_mode, 1);
    check("fixed_no_cl_writes", wr_addr.size() - w0, 0);
    @(negedge clk);
    pulse_in(2);
    respond(3, "fixed_sym_start");
    check("fixed_done", done, 1);
`else
    @(negedge clk);
    check("btype01_hdr_err", hdr_err, 1);
    check("btype01_fixed", fixed_mode, 0);
    check("btype01_no_cl_writes", wr_addr.size() - w0, 0);
`endif

    // HLIT=30 -> ERR before LENS.
    l0 = n_lens;
    do_start();
    serve(5, 3, "bhdr_h30");
    serve(30, 5, "hlit30");
    serve(0, 5, "hdist_h30");
    check("hlit30_hdr_err", hdr_err, 1);
    repeat (4) @(negedge clk);
    check("hlit30_no_lens", n_lens - l0, 0);

    // Reset while in LENS.
    do_start();
    run_block_dyn(1, 0, 0, 15, 1, 1'b0);
    wait_for(1, "lens_start_rst");
    rst_n = 1'b0;
    #1;
    check("rst_lens_busy", busy, 0);
    check("rst_lens_count", lens_count, 0);
    check("rst_lens_start", lens_start, 0);
    check("rst_lens_bs_len", bs_len, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = n_flush + n_cl + n_lens + n_tree + n_sym + n_done + n_req + wr_addr.size();
    repeat (5) @(negedge clk);
    check("no_pulse_after_rst", n_flush + n_cl + n_lens + n_tree + n_sym + n_done + n_req
          + wr_addr.size() - p0, 0);
    check("idle_after_rst", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
